// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS data-port bridge.
// Imported by the bridge FSM and its timeout counter.
package mips_bus_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE,
        ERR
    } bridge_state_t;

endpackage

// File: rtl/bridge_timeout_counter.sv
// Cycle counter bounding how long one memory access may stay outstanding.
// Flags expiry when the count reaches TIMEOUT.
module bridge_timeout_counter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Count busy cycles; cleared whenever the bridge is not busy.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mips_data_bridge.sv
// Converts combinational CPU data accesses into registered memory requests
// with waitrequest/readdatavalid, stalling the CPU through clk_enable.
module mips_data_bridge
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        timeout_err
);

    bridge_state_t state, state_n;
    logic [31:0]   rdata;
    logic          busy;
    logic          expired;
    logic          capture;
    logic          latch;
    logic          drop;
    logic          set_err;
    logic          clk_en;

    assign busy = (state == REQ) || (state == WAIT_DATA);

    bridge_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .run     (busy),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath controls; completion beats a same-cycle timeout.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        latch   = 1'b0;
        drop    = 1'b0;
        set_err = 1'b0;
        clk_en  = 1'b0;
        unique case (state)
            IDLE: begin
                clk_en = !(cpu_data_read || cpu_data_write);
                if (cpu_data_read && cpu_data_write) begin
                    set_err = 1'b1;
                    state_n = ERR;
                end else if (cpu_data_read || cpu_data_write) begin
                    capture = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    drop = 1'b1;
                    if (mem_write) begin
                        state_n = DONE;
                    end else if (mem_readdatavalid) begin
                        latch   = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT_DATA;
                    end
                end else if (expired) begin
                    drop    = 1'b1;
                    set_err = 1'b1;
                    state_n = ERR;
                end
            end
            WAIT_DATA: begin
                if (mem_readdatavalid) begin
                    latch   = 1'b1;
                    state_n = DONE;
                end else if (expired) begin
                    set_err = 1'b1;
                    state_n = ERR;
                end
            end
            DONE: begin
                clk_en  = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request registers, read-data latch and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            rdata         <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (capture) begin
                mem_address   <= cpu_data_address;
                mem_writedata <= cpu_data_writedata;
                mem_read      <= cpu_data_read;
                mem_write     <= cpu_data_write;
            end else if (drop) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (latch) begin
                rdata <= mem_readdata;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign cpu_clk_enable    = clk_en && reset;
    assign cpu_data_readdata = (state == DONE) ? rdata : 32'h0;

endmodule

// File: tb/tb_mips_data_bridge.sv
// Self-checking bench for mips_data_bridge: scripted memory responses,
// scoreboard of expected CPU read data popped when the CPU is released.
module tb_mips_data_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;

    logic [31:0] a_rd, b_rd, a_addr, b_addr, a_wdata, b_wdata;
    logic        a_en, b_en, a_mrd, b_mrd, a_mwr, b_mwr, a_err, b_err;

    logic [31:0] o_rd, o_addr, o_wdata;
    logic        o_en, o_mrd, o_mwr, o_err;

    bit          sel = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mips_data_bridge dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_data_address   (cpu_addr),
        .cpu_data_read      (cpu_rd),
        .cpu_data_write     (cpu_wr),
        .cpu_data_writedata (cpu_wdata),
        .cpu_data_readdata  (a_rd),
        .cpu_clk_enable     (a_en),
        .mem_address        (a_addr),
        .mem_read           (a_mrd),
        .mem_write          (a_mwr),
        .mem_writedata      (a_wdata),
        .mem_waitrequest    (mem_waitrequest),
        .mem_readdata       (mem_readdata),
        .mem_readdatavalid  (mem_readdatavalid),
        .timeout_err        (a_err)
    );

    mips_data_bridge #(.TIMEOUT(4), .CNT_W(8)) dut_t (
        .clk                (clk),
        .reset              (reset),
        .cpu_data_address   (cpu_addr),
        .cpu_data_read      (cpu_rd),
        .cpu_data_write     (cpu_wr),
        .cpu_data_writedata (cpu_wdata),
        .cpu_data_readdata  (b_rd),
        .cpu_clk_enable     (b_en),
        .mem_address        (b_addr),
        .mem_read           (b_mrd),
        .mem_write          (b_mwr),
        .mem_writedata      (b_wdata),
        .mem_waitrequest    (mem_waitrequest),
        .mem_readdata       (mem_readdata),
        .mem_readdatavalid  (mem_readdatavalid),
        .timeout_err        (b_err)
    );

    assign o_rd    = sel ? b_rd    : a_rd;
    assign o_en    = sel ? b_en    : a_en;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_mrd   = sel ? b_mrd   : a_mrd;
    assign o_mwr   = sel ? b_mwr   : a_mwr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    assign o_err   = sel ? b_err   : a_err;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_rd = '0;
        exp_q.delete();
    endtask

    // One CPU access against a scripted memory: wait_n waitrequest cycles,
    // then read data valid_lat cycles after acceptance (0 = same cycle).
    task automatic do_access(input string name, input bit wr,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int wait_n, input int valid_lat);
        logic [31:0] exp_rd;
        int wcnt, since, strobes, lat, exp_lat;
        bit accepted, done;
        wcnt = 0; since = 0; strobes = 0; lat = 0;
        accepted = 0; done = 0;
        exp_q.push_back(wr ? last_rd : data);
        if (!wr) last_rd = data;
        exp_lat = 3 + wait_n + (wr ? 0 : valid_lat);
        @(posedge clk);
        #1;
        cpu_addr  = addr;
        cpu_wdata = wr ? data : ~data;
        cpu_rd    = !wr;
        cpu_wr    = wr;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            mem_readdatavalid = 1'b0;
            mem_waitrequest   = 1'b0;
            mem_readdata      = 32'hBAD0_BAD0;
            if (o_en) begin
                exp_rd = exp_q.pop_front();
                vectors++;
                if (o_rd !== exp_rd) begin
                    miscompares++;
                    $display("FAIL %s readdata: got %h want %h", name, o_rd, exp_rd);
                end
                lat = c + 1;
                done = 1;
                cpu_rd = 1'b0;
                cpu_wr = 1'b0;
            end else if (o_mrd || o_mwr) begin
                strobes++;
                vectors++;
                if (o_mwr !== wr || o_mrd !== !wr || o_addr !== addr ||
                    (wr && o_wdata !== data)) begin
                    miscompares++;
                    $display("FAIL %s request: got rd=%b wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                             name, o_mrd, o_mwr, o_addr, o_wdata, wr, addr, data);
                end
                mem_waitrequest = (wcnt < wait_n);
                wcnt++;
                if (!mem_waitrequest) begin
                    accepted = 1;
                    since = 0;
                    if (!wr && valid_lat == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata = data;
                    end
                end
            end else if (accepted && !wr) begin
                since++;
                if (since == valid_lat) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = data;
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s completion: got none in 64 cycles want latency %0d", name, exp_lat);
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        vectors++;
        if (strobes != wait_n + 1) begin
            miscompares++;
            $display("FAIL %s strobe_cycles: got %0d want %0d", name, strobes, wait_n + 1);
        end
    endtask

    task automatic test_reset;
        sel = 0;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_en_low: got %b want 0", o_en);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (o_en !== 1'b1 || o_mrd !== 1'b0 || o_mwr !== 1'b0 ||
                o_err !== 1'b0 || o_rd !== 32'h0 || o_addr !== 32'h0) begin
                miscompares++;
                $display("FAIL idle: got en=%b rd=%b wr=%b err=%b data=%h a=%h want 1 0 0 0 0 0",
                         o_en, o_mrd, o_mwr, o_err, o_rd, o_addr);
            end
        end
    endtask

    task automatic test_write;
        sel = 0;
        do_access("write0", 1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0);
    endtask

    task automatic test_read;
        sel = 0;
        do_access("read_wait", 0, 32'h0000_2004, 32'h1234_5678, 2, 3);
        do_access("read_same", 0, 32'h0000_3008, 32'hCAFE_F00D, 0, 0);
    endtask

    task automatic test_back_to_back;
        sel = 0;
        do_access("b2b_wr1", 1, 32'h0000_0100, 32'h0101_0101, 1, 0);
        do_access("b2b_rd1", 0, 32'h0000_0104, 32'hA5A5_5A5A, 0, 1);
        do_access("b2b_wr2", 1, 32'hFFFF_FFFC, 32'hFFFF_0000, 3, 0);
        do_access("b2b_rd2", 0, 32'h8000_0000, 32'h0000_0001, 1, 2);
    endtask

    task automatic test_timeout_edge;
        do_reset();
        sel = 1;
        do_access("to_edge", 0, 32'h0000_0040, 32'h55AA_55AA, 0, 4);
        @(negedge clk);
        vectors++;
        if (o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_edge_err: got %b want 0", o_err);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        sel = 1;
        @(posedge clk);
        #1;
        cpu_addr = 32'h0000_0080;
        cpu_rd = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_waitrequest = 1'b0;
            mem_readdatavalid = 1'b0;
            vectors++;
            if (o_en !== 1'b0 || o_err !== 1'b0) begin
                miscompares++;
                $display("FAIL to_wait c%0d: got en=%b err=%b want 0 0", c, o_en, o_err);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (o_err !== 1'b1 || o_en !== 1'b0 || o_mrd !== 1'b0) begin
                miscompares++;
                $display("FAIL to_err c%0d: got err=%b en=%b rd=%b want 1 0 0",
                         c, o_err, o_en, o_mrd);
            end
        end
        reset = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b0) begin
            miscompares++;
            $display("FAIL to_rst_en: got %b want 0", o_en);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_err !== 1'b0 || o_en !== 1'b1 || o_addr !== 32'h0 ||
            o_mrd !== 1'b0 || o_rd !== 32'h0) begin
            miscompares++;
            $display("FAIL to_rst: got err=%b en=%b a=%h rd=%b data=%h want 0 1 0 0 0",
                     o_err, o_en, o_addr, o_mrd, o_rd);
        end
        last_rd = '0;
    endtask

    task automatic test_both;
        do_reset();
        sel = 0;
        @(posedge clk);
        #1;
        cpu_addr = 32'h0000_0200;
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_err !== 1'b0 || o_en !== 1'b0) begin
            miscompares++;
            $display("FAIL both_idle: got err=%b en=%b want 0 0", o_err, o_en);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (o_err !== 1'b1 || o_mrd !== 1'b0 || o_mwr !== 1'b0 || o_en !== 1'b0) begin
                miscompares++;
                $display("FAIL both c%0d: got err=%b rd=%b wr=%b en=%b want 1 0 0 0",
                         c, o_err, o_mrd, o_mwr, o_en);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid;
        do_reset();
        sel = 0;
        @(posedge clk);
        #1;
        cpu_addr = 32'h0000_5000;
        cpu_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_waitrequest = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_mrd !== 1'b0 || o_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_wait: got rd=%b en=%b want 0 0", o_mrd, o_en);
        end
        reset = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem_readdatavalid = 1'b1;
        mem_readdata = 32'h7777_7777;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (o_en !== 1'b1 || o_rd !== 32'h0 || o_mrd !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_idle c%0d: got en=%b data=%h rd=%b want 1 0 0",
                         c, o_en, o_rd, o_mrd);
            end
            @(negedge clk);
        end
        last_rd = '0;
        do_access("mid_wr", 1, 32'h0000_6000, 32'h1111_2222, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout_edge();
        test_timeout();
        test_both();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
